// File: rtl/id_ex_reg_pkg.sv
// Shared CPU definitions for the ID/EX boundary: default widths, register-index
// width, control-bundle field offsets and the per-edge update action encoding.
package id_ex_reg_pkg;

    localparam int unsigned DEF_DW     = 32;
    localparam int unsigned DEF_CTRL_W = 12;
    localparam int unsigned DEF_CNT_W  = 16;
    localparam int unsigned REG_W      = 5;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    // Field offsets inside the opaque control bundle; EX/MEM/WB decode these.
    localparam int unsigned CTRL_ALUOP_LSB    = 0;
    localparam int unsigned CTRL_ALUOP_W      = 4;
    localparam int unsigned CTRL_ALUSRC_BIT   = 4;
    localparam int unsigned CTRL_MEMTOREG_BIT = 5;
    localparam int unsigned CTRL_REGDST_BIT   = 6;
    localparam int unsigned CTRL_BRANCH_BIT   = 7;
    localparam int unsigned CTRL_JUMP_BIT     = 8;

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FLUSH,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_LOAD
    } upd_act_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard equation: a load in EX whose destination is read by the
// instruction currently in ID. Writes to $0 never create a dependency.
module load_use_detect
    import id_ex_reg_pkg::*;
(
    input  logic             i_ex_valid,
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    output logic             o_hazard
);

    logic w_rt_match;

    assign w_rt_match = (i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt);
    assign o_hazard   = i_ex_valid & i_ex_mem_read & (i_ex_rt != ZERO_REG)
                      & i_id_valid & w_rt_match;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// downstream hold and a saturating bubble counter.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned CTRL_W = DEF_CTRL_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [DW-1:0]     id_pc,
    input  logic [DW-1:0]     id_rs_data,
    input  logic [DW-1:0]     id_rt_data,
    input  logic [DW-1:0]     id_ext_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_reg_write,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [DW-1:0]     ex_pc,
    output logic [DW-1:0]     ex_rs_data,
    output logic [DW-1:0]     ex_rt_data,
    output logic [DW-1:0]     ex_ext_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              r_valid;
    logic [DW-1:0]     r_pc;
    logic [DW-1:0]     r_rs_data;
    logic [DW-1:0]     r_rt_data;
    logic [DW-1:0]     r_ext_imm;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_rd;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_reg_write;
    logic [CTRL_W-1:0] r_ctrl;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic              w_hazard;
    upd_act_e          w_act;

    load_use_detect u_load_use_detect (
        .i_ex_valid    (r_valid),
        .i_ex_mem_read (r_mem_read),
        .i_ex_rt       (r_rt),
        .i_id_valid    (id_valid),
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .o_hazard      (w_hazard)
    );

    // A taken branch kills the dependent instruction, so it never needs to stall.
    assign id_stall = ex_hold | (w_hazard & ~flush);

    always_comb begin
        w_act = ACT_LOAD;
        if (rst) begin
            w_act = ACT_RESET;
        end else if (flush) begin
            w_act = ACT_FLUSH;
        end else if (ex_hold) begin
            w_act = ACT_HOLD;
        end else if (w_hazard) begin
            w_act = ACT_BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        case (w_act)
            ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
                r_valid     <= 1'b0;
                r_pc        <= '0;
                r_rs_data   <= '0;
                r_rt_data   <= '0;
                r_ext_imm   <= '0;
                r_rs        <= '0;
                r_rt        <= '0;
                r_rd        <= '0;
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
                r_reg_write <= 1'b0;
                r_ctrl      <= '0;
            end
            ACT_LOAD: begin
                r_valid     <= id_valid;
                r_pc        <= id_pc;
                r_rs_data   <= id_rs_data;
                r_rt_data   <= id_rt_data;
                r_ext_imm   <= id_ext_imm;
                r_rs        <= id_rs;
                r_rt        <= id_rt;
                r_rd        <= id_rd;
                r_mem_read  <= id_valid & id_mem_read;
                r_mem_write <= id_valid & id_mem_write;
                r_reg_write <= id_valid & id_reg_write;
                r_ctrl      <= id_valid ? id_ctrl : '0;
            end
            default: begin
            end
        endcase

        if (w_act == ACT_RESET) begin
            r_bubble_cnt <= '0;
        end else if (w_act == ACT_BUBBLE && r_bubble_cnt != '1) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign ex_valid     = r_valid;
    assign ex_pc        = r_pc;
    assign ex_rs_data   = r_rs_data;
    assign ex_rt_data   = r_rt_data;
    assign ex_ext_imm   = r_ext_imm;
    assign ex_rs        = r_rs;
    assign ex_rt        = r_rt;
    assign ex_rd        = r_rd;
    assign ex_mem_read  = r_mem_read;
    assign ex_mem_write = r_mem_write;
    assign ex_reg_write = r_reg_write;
    assign ex_ctrl      = r_ctrl;
    assign bubble_cnt   = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: the driver pushes the expected stall and
// post-edge EX state per cycle; a monitor pops and compares after each edge.
module tb_id_ex_reg;

    localparam int unsigned TB_CNT_W = 10;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        mr;
        logic        mw;
        logic        rw;
        logic [11:0] ctrl;
    } ex_t;

    typedef struct packed {
        logic                chk_stall;
        logic                stall;
        ex_t                 ex;
        logic [TB_CNT_W-1:0] cnt;
    } item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    ex_t  r_id = '0;
    logic r_rst = 1'b1;
    logic r_flush = 1'b0;
    logic r_hold = 1'b0;

    logic                w_stall, w_valid, w_mr, w_mw, w_rw;
    logic [31:0]         w_pc, w_rsd, w_rtd, w_imm;
    logic [4:0]          w_rs, w_rt, w_rd;
    logic [11:0]         w_ctrl;
    logic [TB_CNT_W-1:0] w_cnt;

    id_ex_reg #(.DW(32), .CTRL_W(12), .CNT_W(TB_CNT_W)) dut (
        .clk          (clk),
        .rst          (r_rst),
        .id_valid     (r_id.v),
        .id_pc        (r_id.pc),
        .id_rs_data   (r_id.rsd),
        .id_rt_data   (r_id.rtd),
        .id_ext_imm   (r_id.imm),
        .id_rs        (r_id.rs),
        .id_rt        (r_id.rt),
        .id_rd        (r_id.rd),
        .id_mem_read  (r_id.mr),
        .id_mem_write (r_id.mw),
        .id_reg_write (r_id.rw),
        .id_ctrl      (r_id.ctrl),
        .flush        (r_flush),
        .ex_hold      (r_hold),
        .id_stall     (w_stall),
        .ex_valid     (w_valid),
        .ex_pc        (w_pc),
        .ex_rs_data   (w_rsd),
        .ex_rt_data   (w_rtd),
        .ex_ext_imm   (w_imm),
        .ex_rs        (w_rs),
        .ex_rt        (w_rt),
        .ex_rd        (w_rd),
        .ex_mem_read  (w_mr),
        .ex_mem_write (w_mw),
        .ex_reg_write (w_rw),
        .ex_ctrl      (w_ctrl),
        .bubble_cnt   (w_cnt)
    );

    int    checks = 0;
    int    errors = 0;
    item_t q[$];

    ex_t                 m_ex = '0;
    logic [TB_CNT_W-1:0] m_cnt = '0;
    logic                m_known = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ex_t mk(input logic v, input logic [31:0] pc, input logic [31:0] rsd,
                               input logic [31:0] rtd, input logic [31:0] imm,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic mr, input logic mw, input logic rw,
                               input logic [11:0] ctrl);
        ex_t e;
        e.v = v; e.pc = pc; e.rsd = rsd; e.rtd = rtd; e.imm = imm;
        e.rs = rs; e.rt = rt; e.rd = rd; e.mr = mr; e.mw = mw; e.rw = rw; e.ctrl = ctrl;
        return e;
    endfunction

    // Applies one cycle of inputs (just after a falling edge) and records what
    // the EX side must look like after the coming rising edge.
    task automatic cyc(input ex_t id, input logic r, input logic f, input logic h);
        item_t it;
        logic  haz;
        r_id = id; r_rst = r; r_flush = f; r_hold = h;
        haz = m_ex.v && m_ex.mr && (m_ex.rt != 5'd0) && id.v
              && ((m_ex.rt == id.rs) || (m_ex.rt == id.rt));
        it.chk_stall = m_known;
        it.stall = h | (haz & ~f);
        if (r) begin
            m_ex = '0; m_cnt = '0; m_known = 1'b1;
        end else if (f) begin
            m_ex = '0;
        end else if (h) begin
            m_ex = m_ex;
        end else if (haz) begin
            m_ex = '0;
            if (m_cnt != {TB_CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        end else begin
            m_ex = id;
            if (!id.v) begin
                m_ex.mr = 1'b0; m_ex.mw = 1'b0; m_ex.rw = 1'b0; m_ex.ctrl = '0;
            end
        end
        it.ex = m_ex;
        it.cnt = m_cnt;
        q.push_back(it);
        @(negedge clk);
    endtask

    initial begin : monitor
        item_t it;
        logic  s;
        forever begin
            @(negedge clk);
            #4;
            s = w_stall;
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                it = q.pop_front();
                if (it.chk_stall) chk("id_stall", 64'(s), 64'(it.stall));
                chk("ex_valid",     64'(w_valid), 64'(it.ex.v));
                chk("ex_pc",        64'(w_pc),    64'(it.ex.pc));
                chk("ex_rs_data",   64'(w_rsd),   64'(it.ex.rsd));
                chk("ex_rt_data",   64'(w_rtd),   64'(it.ex.rtd));
                chk("ex_ext_imm",   64'(w_imm),   64'(it.ex.imm));
                chk("ex_rs",        64'(w_rs),    64'(it.ex.rs));
                chk("ex_rt",        64'(w_rt),    64'(it.ex.rt));
                chk("ex_rd",        64'(w_rd),    64'(it.ex.rd));
                chk("ex_mem_read",  64'(w_mr),    64'(it.ex.mr));
                chk("ex_mem_write", 64'(w_mw),    64'(it.ex.mw));
                chk("ex_reg_write", 64'(w_rw),    64'(it.ex.rw));
                chk("ex_ctrl",      64'(w_ctrl),  64'(it.ex.ctrl));
                chk("bubble_cnt",   64'(w_cnt),   64'(it.cnt));
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin : driver
        ex_t lw9, add9, lw0, use0, lw9b, ind, alu, nv, lwself;
        int  drain;
        lw9    = mk(1, 32'h0000_0100, 32'h1000_0000, 32'h0, 32'h0000_0004, 5'd29, 5'd9, 5'd0, 1, 0, 1, 12'h021);
        add9   = mk(1, 32'h0000_0108, 32'h0000_0011, 32'h0000_0022, 32'h0, 5'd9, 5'd3, 5'd10, 0, 0, 1, 12'h042);
        lw0    = mk(1, 32'h0000_0200, 32'h0, 32'h0, 32'h0, 5'd4, 5'd0, 5'd0, 1, 0, 1, 12'h021);
        use0   = mk(1, 32'h0000_0204, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd6, 0, 0, 1, 12'h042);
        lw9b   = mk(1, 32'h0000_0208, 32'h0, 32'h0, 32'h8, 5'd4, 5'd9, 5'd0, 1, 0, 1, 12'h021);
        ind    = mk(1, 32'h0000_020C, 32'h5, 32'h6, 32'h0, 5'd10, 5'd11, 5'd12, 0, 0, 1, 12'h042);
        alu    = mk(1, 32'h0000_0300, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_7FFF, 5'd1, 5'd2, 5'd3, 0, 1, 0, 12'hFFF);
        nv     = mk(0, 32'h0000_0400, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 5'd7, 5'd8, 5'd9, 1, 1, 1, 12'hABC);
        lwself = mk(1, 32'h0000_0500, 32'h0, 32'h0, 32'h0, 5'd9, 5'd9, 5'd0, 1, 0, 1, 12'h021);

        @(negedge clk);
        // Reset with non-zero ID fields
        cyc(alu, 1, 0, 0);
        chk("reset_ex_valid", 64'(w_valid), 64'h0);
        chk("reset_bubble_cnt", 64'(w_cnt), 64'h0);
        chk("reset_id_stall", 64'(w_stall), 64'h0);

        // Pass-through
        cyc(mk(1, 32'h0000_0104, 32'h0, 32'h0, 32'hFFFF_FFF0, 5'd0, 5'd0, 5'd8, 0, 0, 1, 12'h0), 0, 0, 0);
        chk("pass_pc", 64'(w_pc), 64'h104);
        chk("pass_imm", 64'(w_imm), 64'hFFFF_FFF0);
        chk("pass_rd", 64'(w_rd), 64'd8);
        cyc(alu, 0, 0, 0);

        // Load-use: one bubble, then the dependent add enters EX
        cyc(lw9, 0, 0, 0);
        r_id = add9;
        #1 chk("loaduse_stall_now", 64'(w_stall), 64'h1);
        cyc(add9, 0, 0, 0);
        chk("loaduse_bubble_valid", 64'(w_valid), 64'h0);
        chk("loaduse_bubble_cnt", 64'(w_cnt), 64'h1);
        cyc(add9, 0, 0, 0);
        chk("loaduse_add_rd", 64'(w_rd), 64'd10);

        // $0 destination and non-matching specifiers never stall
        cyc(lw0, 0, 0, 0);
        cyc(use0, 0, 0, 0);
        cyc(lw9b, 0, 0, 0);
        cyc(ind, 0, 0, 0);

        // Flush beats hold and hazard
        cyc(lw9, 0, 0, 0);
        r_id = add9; r_flush = 1'b1; r_hold = 1'b1;
        #1 chk("flush_stall_eq_hold", 64'(w_stall), 64'h1);
        cyc(add9, 0, 1, 1);
        chk("flush_bubble_valid", 64'(w_valid), 64'h0);
        chk("flush_cnt_unchanged", 64'(w_cnt), 64'h1);
        r_id = add9; r_flush = 1'b1; r_hold = 1'b0;
        #1 chk("flush_no_hold_stall", 64'(w_stall), 64'h0);

        // Hold freezes EX for three cycles, including with a hazard pending
        cyc(alu, 0, 0, 0);
        cyc(ind, 0, 0, 1);
        cyc(add9, 0, 0, 1);
        cyc(nv, 0, 0, 1);
        chk("hold_frozen_pc", 64'(w_pc), 64'h300);
        cyc(lw9, 0, 0, 0);
        cyc(add9, 0, 0, 1);
        cyc(add9, 0, 0, 1);
        cyc(add9, 0, 0, 0);
        cyc(add9, 0, 0, 0);

        // Invalid ID instruction: control zeroed, data still captured
        cyc(nv, 0, 0, 0);
        chk("nv_ctrl", 64'(w_ctrl), 64'h0);
        chk("nv_rsd", 64'(w_rsd), 64'h1111_1111);

        // Saturation: a self-dependent load bubbles every other cycle
        for (int i = 0; i < 2100; i++) cyc(lwself, 0, 0, 0);
        chk("sat_cnt", 64'(w_cnt), 64'h3FF);
        for (int i = 0; i < 6; i++) cyc(lwself, 0, 0, 0);
        chk("sat_cnt_hold", 64'(w_cnt), 64'h3FF);

        // Reset mid-hazard, then normal loading resumes
        if (!(w_valid && w_mr)) cyc(lwself, 0, 0, 0);
        cyc(lwself, 1, 0, 0);
        chk("rst_hazard_cnt", 64'(w_cnt), 64'h0);
        cyc(ind, 0, 0, 0);
        chk("rst_resume_valid", 64'(w_valid), 64'h1);
        cyc(mk(0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 12'h0), 0, 0, 0);

        drain = 0;
        while (q.size() > 0 && drain < 5) begin
            @(negedge clk);
            drain++;
        end
        if (q.size() > 0) chk("scoreboard_drain", 64'(q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
